alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared integer ALU. Accepts operand/operation requests from two datapath clients (requester 0: execute stage; requester 1: address/branch helper) over valid/ready handshakes. Grants one request at a time, drives the ALU from registered operands, and captures the result into a held response register. Sits between the clients and the ALU instance; the ALU itself stays purely combinational.

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request, response and ALU-side signal bundle for alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [31:0] alu_read1;
  logic [31:0] alu_read2;
  logic [3:0]  alu_ops;
  logic [31:0] alu_out;
  logic        alu_zero;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_out, alu_zero,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero,
    output alu_read1, alu_read2, alu_ops
  );

  // Client / ALU side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready, alu_out, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero,
    input  alu_read1, alu_read2, alu_ops
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter/sequencer for the shared combinational
//               ALU. Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority;
//               default is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   win0;
  logic   win1;
  logic   can_grant;
  logic   take0;
  logic   take1;
  logic   accept;

  // Grant is open in IDLE, or in RESP on the cycle the response retires.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    win0      = bus.req0_valid;
`else
    win0      = bus.req0_valid & (~bus.req1_valid | last_grant);
`endif
    win1      = bus.req1_valid & ~win0;
    can_grant = (state == IDLE) | ((state == RESP) & bus.rsp_ready);
  end

  assign bus.req0_ready = can_grant & win0;
  assign bus.req1_ready = can_grant & win1;
  assign take0          = bus.req0_valid & bus.req0_ready;
  assign take1          = bus.req1_valid & bus.req1_ready;
  assign accept         = take0 | take1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cur_id        <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= 32'h0;
      bus.rsp_zero  <= 1'b0;
      bus.alu_read1 <= 32'h0;
      bus.alu_read2 <= 32'h0;
      bus.alu_ops   <= 4'h0;
    end else begin
      if (accept) begin
        bus.alu_read1 <= take1 ? bus.req1_a  : bus.req0_a;
        bus.alu_read2 <= take1 ? bus.req1_b  : bus.req0_b;
        bus.alu_ops   <= take1 ? bus.req1_op : bus.req0_op;
        cur_id        <= take1;
        last_grant    <= take1;
      end
      unique case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= bus.alu_out;
          bus.rsp_zero  <= bus.alu_zero;
          bus.rsp_id    <= cur_id;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural ALU on the alu_* side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SRA = 4'hB;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  assign bus.alu_out  = alu_f(bus.alu_ops, bus.alu_read1, bus.alu_read2);
  assign bus.alu_zero = (bus.alu_out == 32'h0);

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic sel, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (sel) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    vecs[0] = '{1'b0, 32'd5,          32'd3,          ALU_SUB, 32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'd7,          32'd7,          ALU_SUB, 32'd0,          1'b1};
    vecs[2] = '{1'b0, 32'h8000_0000,  32'd4,          ALU_SRA, 32'hF800_0000,  1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'h0000_0000,  1'b1};
    vecs[4] = '{1'b0, 32'hF0F0_00FF,  32'h0FF0_0F0F,  ALU_AND, 32'h00F0_000F,  1'b0};
    vecs[5] = '{1'b1, 32'h1234_0000,  32'h0000_5678,  ALU_OR,  32'h1234_5678,  1'b0};

    // Reset state
    tick(); tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_rsp_data",  bus.rsp_data,       32'd0);
    chk("rst_rsp_zero",  32'(bus.rsp_zero),  32'd0);
    chk("rst_alu_read1", bus.alu_read1,      32'd0);
    chk("rst_alu_read2", bus.alu_read2,      32'd0);
    chk("rst_alu_ops",   32'(bus.alu_ops),   32'd0);
    rst_n = 1'b1;
    tick();

    // Single requests, rsp_ready held high
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].sel, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      chk("vec_ready",   32'(vecs[i].sel ? bus.req1_ready : bus.req0_ready), 32'd1);
      chk("vec_other",   32'(vecs[i].sel ? bus.req0_ready : bus.req1_ready), 32'd0);
      tick();
      set_req(vecs[i].sel, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("vec_alu_ops", 32'(bus.alu_ops), 32'(vecs[i].op));
      chk("vec_read1",   bus.alu_read1,    vecs[i].a);
      chk("vec_read2",   bus.alu_read2,    vecs[i].b);
      chk("vec_early",   32'(bus.rsp_valid), 32'd0);
      tick();
      chk("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("vec_rsp_data",  bus.rsp_data,       vecs[i].exp_data);
      chk("vec_rsp_zero",  32'(bus.rsp_zero),  32'(vecs[i].exp_zero));
      chk("vec_rsp_id",    32'(bus.rsp_id),    32'(vecs[i].sel));
      tick();
      chk("vec_retired",   32'(bus.rsp_valid), 32'd0);
    end

    // Reset asserted mid-EXEC discards the operation
    set_req(1'b0, 1'b1, 32'd3, 32'd4, ALU_ADD);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_alu_ops",   32'(bus.alu_ops),   32'd0);
    chk("midrst_alu_read1", bus.alu_read1,      32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Tie arbitration with both requesters continuously valid
    set_req(1'b0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    set_req(1'b1, 1'b1, 32'd2, 32'd2, ALU_ADD);
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (k % 2) == 1;
`endif
      tick(); tick();
      chk("tie_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tie_id",    32'(bus.rsp_id),    32'(exp_id));
      chk("tie_data",  bus.rsp_data,       exp_id ? 32'd4 : 32'd2);
    end
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick();
    chk("tie_drained", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: response held, req1 stalled, then retire+accept same edge
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    set_req(1'b1, 1'b1, 32'd9, 32'd4, ALU_SUB);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
      chk("bp_rsp_valid",  32'(bus.rsp_valid),  32'd1);
      chk("bp_rsp_data",   bus.rsp_data,        32'd2);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("bp_retired",    32'(bus.rsp_valid), 32'd0);
    chk("bp_accept_rd1", bus.alu_read1,      32'd9);
    tick();
    chk("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_next_data",  bus.rsp_data,       32'd5);
    chk("bp_next_id",    32'(bus.rsp_id),    32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
